// File: rtl/cronometru_pkg.sv
// Shared types and digit helpers for the cronometru_lap BCD stopwatch.
package cronometru_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Odd positions of an mm:ss display are the tens of seconds/minutes.
    function automatic bcd_digit_t digit_max(input int index, input int sexagesimal);
        return ((sexagesimal != 0) && ((index % 2) == 1)) ? 4'd5 : 4'd9;
    endfunction

    function automatic bcd_digit_t sat_digit(input bcd_digit_t value, input bcd_digit_t max);
        return (value > max) ? max : value;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch: load, increment with carry, decrement with borrow.
module bcd_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       load,
    input  logic       inc,
    input  logic       dec,
    input  logic [3:0] max,
    input  logic [3:0] load_value,
    output logic [3:0] q,
    output logic       carry_out,
    output logic       borrow_out
);

    assign carry_out  = inc && (q == max);
    assign borrow_out = dec && (q == 4'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= 4'd0;
        end else if (clear) begin
            q <= 4'd0;
        end else if (load) begin
            q <= load_value;
        end else if (inc) begin
            q <= (q == max) ? 4'd0 : q + 4'd1;
        end else if (dec) begin
            q <= (q == 4'd0) ? max : q - 4'd1;
        end
    end

endmodule

// File: rtl/cronometru_lap.sv
// Prescaled up/down BCD stopwatch with preload, lap capture, wrap pulse and
// countdown-done flag; drives the seven-segment display path.
module cronometru_lap
    import cronometru_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 100000,
    parameter int SEXAGESIMAL = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pause,
    input  logic                    clear,
    input  logic                    dir,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [4*NUM_DIGITS-1:0] lap_bcd,
    output logic                    lap_valid,
    output logic                    carry,
    output logic                    done
);

    localparam int            PW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]           presc;
    logic                    run;
    logic                    tick;
    logic                    down_tick;
    logic                    all_zero;
    logic                    one_left;
    logic                    unused_borrow;
    logic [NUM_DIGITS-1:0]   inc_v;
    logic [NUM_DIGITS-1:0]   dec_v;
    logic [NUM_DIGITS-1:0]   carry_v;
    logic [NUM_DIGITS-1:0]   borrow_v;
    logic [NUM_DIGITS-1:0]   is_zero;
    logic [4*NUM_DIGITS-1:0] load_sat;

    // A finished countdown freezes the prescaler until dir, clear or load releases it.
    assign run       = !pause && !(dir && done);
    assign tick      = run && (presc == P_LAST);
    assign down_tick = tick && dir;
    assign all_zero  = &is_zero;
    assign one_left  = (bcd[3:0] == 4'd1) && (&is_zero[NUM_DIGITS-1:1]);

    // Decrement is never issued from all-zero, so the top borrow never fires.
    assign unused_borrow = borrow_v[NUM_DIGITS-1];

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam bcd_digit_t DMAX = digit_max(i, SEXAGESIMAL);

        if (i == 0) begin : g_lsd
            assign inc_v[i] = tick && !dir;
            assign dec_v[i] = down_tick && !all_zero;
        end else begin : g_chain
            assign inc_v[i] = carry_v[i-1];
            assign dec_v[i] = borrow_v[i-1];
        end

        assign load_sat[4*i +: 4] = sat_digit(load_value[4*i +: 4], DMAX);
        assign is_zero[i]         = (bcd[4*i +: 4] == 4'd0);

        bcd_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .clear      (clear),
            .load       (load),
            .inc        (inc_v[i]),
            .dec        (dec_v[i]),
            .max        (DMAX),
            .load_value (load_sat[4*i +: 4]),
            .q          (bcd[4*i +: 4]),
            .carry_out  (carry_v[i]),
            .borrow_out (borrow_v[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
        end else if (clear || load) begin
            presc <= '0;
        end else if (run) begin
            presc <= (presc == P_LAST) ? '0 : presc + 1'b1;
        end
    end

    // Carry out of the top digit means every digit was at its max: full wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            carry <= 1'b0;
            done  <= 1'b0;
        end else if (clear) begin
            carry <= 1'b0;
            done  <= 1'b0;
        end else begin
            carry <= !load && carry_v[NUM_DIGITS-1];
            if (!dir) begin
                done <= 1'b0;
            end else if (load) begin
                if (load_sat != '0) done <= 1'b0;
            end else if (down_tick && (all_zero || one_left)) begin
                done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lap_bcd   <= '0;
            lap_valid <= 1'b0;
        end else if (clear) begin
            lap_bcd   <= '0;
            lap_valid <= 1'b0;
        end else if (lap) begin
            lap_bcd   <= bcd;
            lap_valid <= 1'b1;
        end
    end

endmodule
